psram_arbiter: RTL

- Three-port arbiter and sequencer in front of the PSRAM/HyperRAM word controller on the Tang Nano 9K build.
- Ports: p0 = CPU, p1 = video fetch, p2 = DMA/SD loader.
- Grants one requester at a time, issues a single-cycle read/write command to the controller, tracks the controller's busy, and returns read data with a per-port ack pulse.
- Port 1 gets bounded strict priority; the other ports share round-robin.

---
 rtl/psram_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/psram_arbiter.sv
// Three-port arbiter and command sequencer for the PSRAM word controller.
// Port 1 (video) gets bounded strict priority; ports 0 and 2 share round-robin.
module psram_arbiter #(
  parameter bit PRIO_EN    = 1'b1,
  parameter int MAX_CONSEC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_byte,
  input  logic [21:0] p0_addr,
  input  logic [15:0] p0_wdata,
  output logic        p0_ack,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_byte,
  input  logic [21:0] p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p1_ack,
  input  logic        p2_req,
  input  logic        p2_we,
  input  logic        p2_byte,
  input  logic [21:0] p2_addr,
  input  logic [15:0] p2_wdata,
  output logic        p2_ack,
  output logic [15:0] rdata,
  output logic [1:0]  grant_id,
  output logic        mem_read,
  output logic        mem_write,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_byte_write,
  input  logic [15:0] mem_dout,
  input  logic        mem_busy
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_DONE
  } state_e;

  localparam logic [3:0] MAXC = 4'(MAX_CONSEC);

  state_e      state_q, state_d;
  logic [1:0]  rr_last_q, rr_last_d;
  logic [1:0]  grant_q, grant_d;
  logic [3:0]  consec_q, consec_d;
  logic [2:0]  ack_q, ack_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        is_wr_q, is_wr_d;
  logic        bw_q, bw_d;
  logic [21:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic [15:0] rdata_q, rdata_d;

  logic [3:0]  req;
  logic [3:0]  elig;
  logic [1:0]  c1, c2, c3, win;
  logic        s_we, s_bw;
  logic [21:0] s_addr;
  logic [15:0] s_wdata;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign req = {1'b0, p2_req, p1_req, p0_req};

  always_comb begin
    elig = req;
    // Starved ports force port 1 out of this decision once its burst is spent.
    if (PRIO_EN && consec_q >= MAXC && (req[0] || req[2]))
      elig[1] = 1'b0;
    c1 = nxt(rr_last_q);
    c2 = nxt(c1);
    c3 = rr_last_q;
    if (elig[c1])
      win = c1;
    else if (elig[c2])
      win = c2;
    else
      win = c3;
    if (PRIO_EN && req[1] && consec_q < MAXC)
      win = 2'd1;
  end

  always_comb begin
    s_we    = p0_we;
    s_bw    = p0_byte;
    s_addr  = p0_addr;
    s_wdata = p0_wdata;
    case (win)
      2'd1: begin
        s_we    = p1_we;
        s_bw    = p1_byte;
        s_addr  = p1_addr;
        s_wdata = p1_wdata;
      end
      2'd2: begin
        s_we    = p2_we;
        s_bw    = p2_byte;
        s_addr  = p2_addr;
        s_wdata = p2_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    grant_d   = grant_q;
    consec_d  = consec_q;
    ack_d     = 3'b000;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    is_wr_d   = is_wr_q;
    bw_d      = bw_q;
    addr_d    = addr_q;
    din_d     = din_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (!mem_busy && (|req)) begin
          state_d   = ISSUE;
          grant_d   = win;
          rr_last_d = win;
          addr_d    = s_addr;
          din_d     = s_wdata;
          bw_d      = s_bw;
          is_wr_d   = s_we;
          rd_d      = !s_we;
          wr_d      = s_we;
          if (win == 2'd1 && (req[0] || req[2])
              && consec_q < MAXC)
            consec_d = consec_q + 4'd1;
          else
            consec_d = 4'd0;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (mem_busy)
          state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!mem_busy) begin
          if (!is_wr_q)
            rdata_d = mem_dout;
          ack_d   = 3'b001 << grant_q;
          grant_d = 2'd3;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_last_q <= 2'd2;
      grant_q   <= 2'd3;
      consec_q  <= 4'd0;
      ack_q     <= 3'b000;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      is_wr_q   <= 1'b0;
      bw_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      grant_q   <= grant_d;
      consec_q  <= consec_d;
      ack_q     <= ack_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      is_wr_q   <= is_wr_d;
      bw_q      <= bw_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      rdata_q   <= rdata_d;
    end
  end

  assign p0_ack         = ack_q[0];
  assign p1_ack         = ack_q[1];
  assign p2_ack         = ack_q[2];
  assign rdata          = rdata_q;
  assign grant_id       = grant_q;
  assign mem_read       = rd_q;
  assign mem_write      = wr_q;
  assign mem_addr       = addr_q;
  assign mem_din        = din_q;
  assign mem_byte_write = bw_q;

endmodule
